arith_unit_scheduler: RTL and testbench
=======================================

ARITH_UNIT_SCHEDULER -- requirements
Module: arith_unit_scheduler

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result width of the shared arithmetic unit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  2  per-requester command valid; bit i = requester i.
REQ-005 req_ready  output  2  per-requester grant/accept strobe.
REQ-006 req_op  input  6  per-requester select {S1,S0,Cin}; bits [3i+2:3i] = requester i.
REQ-007 req_a  input  2*WIDTH  per-requester operand A; slice i = requester i.
REQ-008 req_b  input  2*WIDTH  per-requester operand B; slice i = requester i.
REQ-009 req_cnt  input  4  per-requester repeat count; bits [2i+1:2i]; iterations = cnt+1.
REQ-010 alu_a, alu_b  output  WIDTH each  operands driven to the shared unit.
REQ-011 alu_s1, alu_s0, alu_cin  output  1 each  function select to the shared unit.
REQ-012 alu_d  input  WIDTH  shared unit result (combinational from alu_* outputs).
REQ-013 alu_cout  input  1  shared unit carry-out.
REQ-014 rsp_valid  output  1  result available.
REQ-015 rsp_ready  input  1  consumer accepts result.
REQ-016 rsp_id, rsp_d, rsp_cout  output  1 / WIDTH / 1  granted requester, final result, final carry.

Function
REQ-017 FSM states SHALL be IDLE, EXEC, RESP; reset state IDLE.
REQ-018 IDLE: if any req_valid set, grant exactly one requester that cycle; req_ready[g] = 1 combinationally, other bit 0; capture op, a (into accumulator), b, cnt, id; go to EXEC.
REQ-019 req_ready SHALL be 0 in EXEC and RESP; no capture outside IDLE.
REQ-020 Arbitration SHALL be round-robin: priority pointer favours requester 0 after reset; after each grant the pointer favours the other requester; only one valid -> that one granted regardless of pointer.
REQ-021 Requesters hold valid and command stable until ready; a valid dropped before grant is never granted.
REQ-022 EXEC: alu_a = accumulator, alu_b = captured b, {alu_s1,alu_s0,alu_cin} = captured op; each cycle accumulator <= alu_d, carry register <= alu_cout, iteration counter decrements.
REQ-023 EXEC SHALL last exactly cnt+1 cycles, then go to RESP.
REQ-024 Outside EXEC, alu_a, alu_b, alu_s1, alu_s0, alu_cin SHALL be 0.
REQ-025 RESP: rsp_valid = 1, rsp_d = accumulator, rsp_cout = carry of last iteration, rsp_id = granted index; all stable until rsp_ready.
REQ-026 RESP with rsp_ready = 1 -> IDLE next cycle; rsp_ready = 0 -> hold RESP indefinitely (back-pressure; no new grants).
REQ-027 Latency: grant at cycle T, rsp_valid first high at T+cnt+2; minimum issue interval cnt+3 cycles.
REQ-028 Arithmetic wraps modulo 2^WIDTH; carry beyond WIDTH reported only via rsp_cout.

Reset
REQ-029 rst high (any state, including mid-EXEC) SHALL immediately force: state IDLE, req_ready 0, rsp_valid 0, rsp_id 0, rsp_d 0, rsp_cout 0, alu_* outputs 0, pointer to requester 0, counters 0; in-flight command discarded.
REQ-030 First grant possible in the first cycle after rst deasserts.

Verification
REQ-031 Req0 only: op=000, a=5, b=2, cnt=0 -> req_ready=01 one cycle, rsp_valid 2 cycles later, rsp_d=7, rsp_cout=0, rsp_id=0.
REQ-032 Req1 only: op=011 (A+B'+1), a=5, b=2, cnt=0 -> rsp_d=3, rsp_cout=1, rsp_id=1.
REQ-033 Req0: op=000, a=5, b=2, cnt=3 -> 4 EXEC cycles, rsp_valid at T+5, rsp_d=4'hD, rsp_cout=0.
REQ-034 Req0: op=101, a=4'hF, cnt=0 -> rsp_d=0, rsp_cout=1; op=110, a=0, cnt=1 -> rsp_d=4'hE, rsp_cout=1.
REQ-035 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_d stable, req_ready stays 00.
REQ-036 rst asserted during EXEC of cnt=3 command -> all outputs 0 immediately, no response emitted; next simultaneous request grants requester 0.

Source files
------------

// File: rtl/arith_unit_scheduler.sv
// Round-robin scheduler that time-shares one external arithmetic unit between
// two requesters, iterating each command cnt+1 times before returning the result.
module arith_unit_scheduler #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [5:0]         req_op,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [3:0]         req_cnt,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic               alu_s1,
  output logic               alu_s0,
  output logic               alu_cin,
  input  logic [WIDTH-1:0]   alu_d,
  input  logic               alu_cout,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_d,
  output logic               rsp_cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               id_q, id_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [1:0]         cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               gnt_id_s;
  logic [1:0]         ready_s;

  // With both requesters valid the pointer decides; otherwise the lone valid one wins.
  assign gnt_id_s  = (req_valid == 2'b11) ? ptr_q : req_valid[1];
  assign req_ready = ready_s & {2{~rst}};

  // State, operand and result registers; reset discards any in-flight command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= 3'b000;
      acc_q   <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      cnt_q   <= 2'b00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
    end
  end

  // Next-state logic, grant decode and datapath steering.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    op_d      = op_q;
    acc_d     = acc_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    ready_s   = 2'b00;
    alu_a     = {WIDTH{1'b0}};
    alu_b     = {WIDTH{1'b0}};
    alu_s1    = 1'b0;
    alu_s0    = 1'b0;
    alu_cin   = 1'b0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_d     = {WIDTH{1'b0}};
    rsp_cout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          ready_s[gnt_id_s] = 1'b1;
          id_d    = gnt_id_s;
          ptr_d   = ~gnt_id_s;
          op_d    = gnt_id_s ? req_op[5:3] : req_op[2:0];
          acc_d   = gnt_id_s ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
          b_d     = gnt_id_s ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
          cnt_d   = gnt_id_s ? req_cnt[3:2] : req_cnt[1:0];
          carry_d = 1'b0;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        alu_a   = acc_q;
        alu_b   = b_q;
        {alu_s1, alu_s0, alu_cin} = op_q;
        acc_d   = alu_d;
        carry_d = alu_cout;
        if (cnt_q == 2'b00) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'b01;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_d     = acc_q;
        rsp_cout  = carry_q;
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_arith_unit_scheduler.sv
// Bench for arith_unit_scheduler: models the shared unit as A + Bsel + Cin where
// {S1,S0} picks Bsel = B, ~B, 0 or all-ones, then applies a vector table and corner sequences.
module tb_arith_unit_scheduler;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = 2'b00;
  logic [1:0]   req_ready;
  logic [5:0]   req_op = 6'd0;
  logic [7:0]   req_a = 8'd0;
  logic [7:0]   req_b = 8'd0;
  logic [3:0]   req_cnt = 4'd0;
  logic [W-1:0] alu_a, alu_b, alu_d;
  logic         alu_s1, alu_s0, alu_cin, alu_cout;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_id;
  logic [W-1:0] rsp_d;
  logic         rsp_cout;

  int n_total = 0;
  int n_pass  = 0;

  arith_unit_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cnt(req_cnt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s1(alu_s1), .alu_s0(alu_s0), .alu_cin(alu_cin),
    .alu_d(alu_d), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_d(rsp_d), .rsp_cout(rsp_cout)
  );

  always #5 clk = ~clk;

  // Shared arithmetic unit model
  logic [W-1:0] bsel;
  logic [W:0]   sum;
  always_comb begin
    case ({alu_s1, alu_s0})
      2'b00:   bsel = alu_b;
      2'b01:   bsel = ~alu_b;
      2'b10:   bsel = {W{1'b0}};
      default: bsel = {W{1'b1}};
    endcase
    sum = {1'b0, alu_a} + {1'b0, bsel} + {{W{1'b0}}, alu_cin};
  end
  assign alu_d    = sum[W-1:0];
  assign alu_cout = sum[W];

  typedef struct {
    logic [1:0] valid;
    logic [2:0] op0; logic [3:0] a0; logic [3:0] b0; logic [1:0] cnt0;
    logic [2:0] op1; logic [3:0] a1; logic [3:0] b1; logic [1:0] cnt1;
    logic       id;  logic [3:0] d;  logic       cout; int lat;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_req_ready"}, int'(req_ready), 0);
    check({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    check({tag, "_rsp_d"}, int'(rsp_d), 0);
    check({tag, "_rsp_id"}, int'(rsp_id), 0);
    check({tag, "_rsp_cout"}, int'(rsp_cout), 0);
    check({tag, "_alu_ab"}, int'({alu_a, alu_b}), 0);
    check({tag, "_alu_sel"}, int'({alu_s1, alu_s0, alu_cin}), 0);
  endtask

  initial begin
    int lat;
    int n;
    logic [3:0] held_d;
    vecs[0] = '{2'b01, 3'b000, 4'd5, 4'd2, 2'd0, 3'b000, 4'd0, 4'd0, 2'd0, 1'b0, 4'd7,  1'b0, 2};
    vecs[1] = '{2'b10, 3'b000, 4'd0, 4'd0, 2'd0, 3'b011, 4'd5, 4'd2, 2'd0, 1'b1, 4'd3,  1'b1, 2};
    vecs[2] = '{2'b01, 3'b000, 4'd5, 4'd2, 2'd3, 3'b000, 4'd0, 4'd0, 2'd0, 1'b0, 4'hD,  1'b0, 5};
    vecs[3] = '{2'b01, 3'b101, 4'hF, 4'd0, 2'd0, 3'b000, 4'd0, 4'd0, 2'd0, 1'b0, 4'h0,  1'b1, 2};
    vecs[4] = '{2'b01, 3'b110, 4'h0, 4'd0, 2'd1, 3'b000, 4'd0, 4'd0, 2'd0, 1'b0, 4'hE,  1'b1, 3};
    vecs[5] = '{2'b11, 3'b000, 4'd1, 4'd1, 2'd0, 3'b001, 4'd3, 4'd1, 2'd2, 1'b1, 4'd9,  1'b0, 4};
    vecs[6] = '{2'b10, 3'b000, 4'd0, 4'd0, 2'd0, 3'b100, 4'd7, 4'd5, 2'd0, 1'b1, 4'd7,  1'b0, 2};
    vecs[7] = '{2'b10, 3'b000, 4'd0, 4'd0, 2'd0, 3'b111, 4'd3, 4'd5, 2'd0, 1'b1, 4'd3,  1'b1, 2};

    repeat (2) @(negedge clk);
    #1 check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table: grant strobe, first-EXEC operand, latency and result for each command
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      req_op    = {vecs[i].op1, vecs[i].op0};
      req_a     = {vecs[i].a1, vecs[i].a0};
      req_b     = {vecs[i].b1, vecs[i].b0};
      req_cnt   = {vecs[i].cnt1, vecs[i].cnt0};
      #1 check($sformatf("v%0d_ready", i), int'(req_ready), vecs[i].id ? 2 : 1);
      @(negedge clk);
      req_valid = 2'b00;
      #1 check($sformatf("v%0d_alu_a", i), int'(alu_a), vecs[i].id ? int'(vecs[i].a1) : int'(vecs[i].a0));
      check($sformatf("v%0d_exec_ready", i), int'(req_ready), 0);
      wait_rsp(lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("v%0d_id", i), int'(rsp_id), int'(vecs[i].id));
      check($sformatf("v%0d_d", i), int'(rsp_d), int'(vecs[i].d));
      check($sformatf("v%0d_cout", i), int'(rsp_cout), int'(vecs[i].cout));
    end
    @(negedge clk);
    #1 check("post_table_idle", int'(rsp_valid), 0);

    // Both requesters valid continuously: grants alternate 0,1,0,1
    req_op = 6'b000_000; req_a = {4'd2, 4'd1}; req_b = {4'd2, 4'd1}; req_cnt = 4'd0;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(n);
      check($sformatf("alt%0d_grant", k), int'(req_ready), (k % 2 == 0) ? 1 : 2);
      @(negedge clk);
      #1;
    end
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    // Back-pressure: response held stable, no new grants while rsp_ready low
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #1 wait_grant(n);
    check("bp_grant", int'(req_ready), 1);
    @(negedge clk);
    wait_rsp(lat);
    check("bp_valid", int'(rsp_valid), 1);
    held_d = rsp_d;
    check("bp_d", int'(held_d), 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("bp%0d_valid", k), int'(rsp_valid), 1);
      check($sformatf("bp%0d_d", k), int'(rsp_d), int'(held_d));
      check($sformatf("bp%0d_ready", k), int'(req_ready), 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1 check("bp_release", int'(rsp_valid), 0);

    // Reset in the middle of a cnt=3 command
    req_op = 6'b000_000; req_a = {4'd0, 4'd5}; req_b = {4'd0, 4'd2}; req_cnt = 4'b00_11;
    req_valid = 2'b01;
    #1 check("mid_grant", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 check("mid_exec_alu_a", int'(alu_a), 7);
    req_valid = 2'b11;
    rst = 1'b1;
    #1 check_quiet("mid_rst");
    @(negedge clk);
    req_cnt = 4'b00_00;
    rst = 1'b0;
    #1 check("post_rst_grant", int'(req_ready), 1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_d", int'(rsp_d), 7);
    check("post_rst_id", int'(rsp_id), 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
